// File: rtl/div_seq.sv
// div_seq: multi-cycle integer divider for the EX stage of an RV32IM pipeline.
// Handles DIV/DIVU/REM/REMU with a 32-iteration restoring divider and stalls
// the front of the pipeline while it iterates. Divide-by-zero and signed
// overflow are resolved at capture time and complete after a single cycle.
module div_seq #(
    parameter int         XLEN     = 32,
    parameter logic [4:0] ALU_DIV  = 5'd12,
    parameter logic [4:0] ALU_DIVU = 5'd13,
    parameter logic [4:0] ALU_REM  = 5'd14,
    parameter logic [4:0] ALU_REMU = 5'd15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_vld,
    input  logic [4:0]      ex_alu_func,
    input  logic [XLEN-1:0] ex_opa,
    input  logic [XLEN-1:0] ex_opb,
    input  logic [5:0]      ex_rd,
    input  logic            flush,
    output logic            div_stall,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output logic [5:0]      div_rd
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic            is_rem_reg;
    logic            special_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [XLEN-1:0] dvsr_reg;
    logic [XLEN-1:0] q_reg;
    logic [XLEN-1:0] rem_reg;
    logic [5:0]      rd_reg;
    logic [XLEN-1:0] hold_result_reg;
    logic [5:0]      hold_rd_reg;

    logic            is_div_func;
    logic            div_op;
    logic            is_signed_op;
    logic            is_rem_op;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_val;

    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] q_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] q_step;

    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic [XLEN-1:0] final_result;

    // Decode the presented instruction and precompute magnitudes / special results.
    always_comb begin
        is_div_func  = (ex_alu_func == ALU_DIV)  || (ex_alu_func == ALU_DIVU) ||
                       (ex_alu_func == ALU_REM)  || (ex_alu_func == ALU_REMU);
        div_op       = ex_vld && is_div_func;
        is_signed_op = (ex_alu_func == ALU_DIV) || (ex_alu_func == ALU_REM);
        is_rem_op    = (ex_alu_func == ALU_REM) || (ex_alu_func == ALU_REMU);
        neg_a        = is_signed_op && ex_opa[XLEN-1];
        neg_b        = is_signed_op && ex_opb[XLEN-1];
        // |MOST_NEG| wraps back to MOST_NEG, which is the right unsigned magnitude.
        mag_a        = neg_a ? (~ex_opa + 1'b1) : ex_opa;
        mag_b        = neg_b ? (~ex_opb + 1'b1) : ex_opb;
        div_by_zero  = (ex_opb == '0);
        overflow     = is_signed_op && (ex_opa == MOST_NEG) && (ex_opb == '1);
        special      = div_by_zero || overflow;
        if (div_by_zero) begin
            special_val = is_rem_op ? ex_opa : '1;
        end else begin
            // Overflow: quotient is the dividend itself, remainder is zero.
            special_val = is_rem_op ? '0 : ex_opa;
        end
    end

    // One restoring-division iteration; the shifted remainder needs XLEN+1 bits.
    always_comb begin
        rem_shift = {rem_reg, q_reg[XLEN-1]};
        q_shift   = {q_reg[XLEN-2:0], 1'b0};
        rem_ge    = (rem_shift >= {1'b0, dvsr_reg});
        rem_step  = rem_shift[XLEN-1:0];
        q_step    = q_shift;
        if (rem_ge) begin
            // The true difference is below the divisor, so XLEN bits hold it exactly.
            rem_step = rem_shift[XLEN-1:0] - dvsr_reg;
            q_step   = q_shift | {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    // Sign fix-up of the finished magnitudes, or the precomputed special value.
    always_comb begin
        q_signed = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
        r_signed = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        if (special_reg) begin
            final_result = q_reg;
        end else if (is_rem_reg) begin
            final_result = r_signed;
        end else begin
            final_result = q_signed;
        end
    end

    // Next-state selection; a flush always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (div_op) state_next = special ? S_DONE : S_BUSY;
                S_BUSY:  if (cnt_reg == CW'(XLEN-1)) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture in IDLE, iteration in BUSY, result hold on leaving DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg         <= '0;
            is_rem_reg      <= 1'b0;
            special_reg     <= 1'b0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            dvsr_reg        <= '0;
            q_reg           <= '0;
            rem_reg         <= '0;
            rd_reg          <= '0;
            hold_result_reg <= '0;
            hold_rd_reg     <= '0;
        end else begin
            if ((state_reg == S_IDLE) && div_op && !flush) begin
                cnt_reg     <= '0;
                is_rem_reg  <= is_rem_op;
                special_reg <= special;
                neg_q_reg   <= neg_a ^ neg_b;
                neg_r_reg   <= neg_a;
                dvsr_reg    <= mag_b;
                q_reg       <= special ? special_val : mag_a;
                rem_reg     <= '0;
                rd_reg      <= ex_rd;
            end else if (state_reg == S_BUSY) begin
                q_reg   <= q_step;
                rem_reg <= rem_step;
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == S_DONE) begin
                hold_result_reg <= final_result;
                hold_rd_reg     <= rd_reg;
            end
        end
    end

    // Outputs: stall from state and inputs, completion data from DONE registers.
    always_comb begin
        div_stall  = !flush && (((state_reg == S_IDLE) && div_op) || (state_reg == S_BUSY));
        div_done   = (state_reg == S_DONE) && !flush;
        div_result = (state_reg == S_DONE) ? final_result : hold_result_reg;
        div_rd     = (state_reg == S_DONE) ? rd_reg : hold_rd_reg;
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed corner cases plus randomized operations,
// each checked against an arithmetic reference model.
module tb_div_seq;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_DIVU = 5'd13;
    localparam logic [4:0] ALU_REM  = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_vld;
    logic [4:0]  ex_alu_func;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic [5:0]  ex_rd;
    logic        flush;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;
    logic [5:0]  div_rd;

    int compared   = 0;
    int mismatched = 0;

    div_seq #(
        .XLEN     (32),
        .ALU_DIV  (ALU_DIV),
        .ALU_DIVU (ALU_DIVU),
        .ALU_REM  (ALU_REM),
        .ALU_REMU (ALU_REMU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_vld      (ex_vld),
        .ex_alu_func (ex_alu_func),
        .ex_opa      (ex_opa),
        .ex_opb      (ex_opb),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .div_stall   (div_stall),
        .div_done    (div_done),
        .div_result  (div_result),
        .div_rd      (div_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (f == ALU_DIV) || (f == ALU_REM);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: RISC-V M-extension semantics using plain integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return ((f == ALU_DIV) || (f == ALU_DIVU)) ? 32'hFFFF_FFFF : a;
        if (is_special(f, a, b)) return (f == ALU_DIV) ? 32'h8000_0000 : 32'd0;
        case (f)
            ALU_DIV:  begin sr = sa / sb; return sr; end
            ALU_REM:  begin sr = sa % sb; return sr; end
            ALU_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic string fname(input logic [4:0] f);
        case (f)
            ALU_DIV:  return "DIV ";
            ALU_DIVU: return "DIVU";
            ALU_REM:  return "REM ";
            ALU_REMU: return "REMU";
            default:  return "OTHR";
        endcase
    endfunction

    // Present one div op in the current cycle and follow it to its done pulse.
    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] rd, output time t_done);
        logic [31:0] exp_q;
        int          exp_lat;
        int          cyc;
        int          stalls;
        bit          got;
        exp_q   = model(f, a, b);
        exp_lat = is_special(f, a, b) ? 1 : 33;
        ex_vld = 1'b1; ex_alu_func = f; ex_opa = a; ex_opb = b; ex_rd = rd; flush = 1'b0;
        cyc = 0; stalls = 0; got = 0; t_done = 0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (div_done) begin
                got    = 1;
                t_done = $time;
                check("done_cycle", cyc, exp_lat);
                check("stall_in_done", {31'd0, div_stall}, 32'd0);
                check("result", div_result, exp_q);
                check("rd", {26'd0, div_rd}, {26'd0, rd});
            end else begin
                if (div_stall) stalls++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("stall_cycles", stalls, exp_lat);
        $display("op %s a=%h b=%h rd=%0d -> result=%h done_cycle=%0d stalls=%0d",
                 fname(f), a, b, rd, div_result, cyc, stalls);
        @(posedge clk); #1;
    endtask

    // One idle cycle after an op: no stall, no repeated pulse, result held.
    task automatic idle_gap(input logic [31:0] exp_res, input logic [5:0] exp_rd);
        ex_vld = 1'b0;
        @(negedge clk);
        check("gap_stall", {31'd0, div_stall}, 32'd0);
        check("gap_done", {31'd0, div_done}, 32'd0);
        check("hold_result", div_result, exp_res);
        check("hold_rd", {26'd0, div_rd}, {26'd0, exp_rd});
        @(posedge clk); #1;
    endtask

    initial begin
        time         t1;
        time         t2;
        logic [4:0]  funcs [4];
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;

        funcs[0] = ALU_DIV; funcs[1] = ALU_DIVU; funcs[2] = ALU_REM; funcs[3] = ALU_REMU;
        rst = 1'b0; ex_vld = 1'b0; ex_alu_func = ALU_ADD; ex_opa = '0; ex_opb = '0;
        ex_rd = '0; flush = 1'b0;

        // Reset state.
        #2;
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_result", div_result, 32'd0);
        check("rst_rd", {26'd0, div_rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(ALU_DIVU, 32'd100, 32'd7, 6'd5, t1);            idle_gap(32'd14, 6'd5);
        do_op(ALU_REMU, 32'd100, 32'd7, 6'd6, t1);            idle_gap(32'd2, 6'd6);
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 6'd7, t1);       idle_gap(32'hFFFF_FFFD, 6'd7);
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 6'd8, t1);       idle_gap(32'hFFFF_FFFF, 6'd8);
        do_op(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 6'd9, t1);       idle_gap(32'hFFFF_FFFD, 6'd9);
        do_op(ALU_DIVU, 32'd5, 32'd0, 6'd10, t1);             idle_gap(32'hFFFF_FFFF, 6'd10);
        do_op(ALU_REMU, 32'd5, 32'd0, 6'd11, t1);             idle_gap(32'd5, 6'd11);
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, t1); idle_gap(32'h8000_0000, 6'd12);
        do_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, t1); idle_gap(32'd0, 6'd13);
        do_op(ALU_DIVU, 32'h8000_0000, 32'd1, 6'd0, t1);      idle_gap(32'h8000_0000, 6'd0);

        // Flush during BUSY iteration 10: no pulse, stall released.
        ex_vld = 1'b1; ex_alu_func = ALU_DIVU; ex_opa = 32'd100; ex_opb = 32'd7; ex_rd = 6'd20;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_done", {31'd0, div_done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; ex_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_flush_stall", {31'd0, div_stall}, 32'd0);
            check("post_flush_done", {31'd0, div_done}, 32'd0);
            @(posedge clk); #1;
        end
        do_op(ALU_DIVU, 32'd9, 32'd3, 6'd21, t1);             idle_gap(32'd3, 6'd21);

        // Back-to-back ops: pulses exactly XLEN+2 cycles apart.
        do_op(ALU_DIVU, 32'd20, 32'd4, 6'd22, t1);
        do_op(ALU_DIVU, 32'd21, 32'd4, 6'd23, t2);
        check("b2b_spacing", 32'(t2 - t1), 32'd340);
        idle_gap(32'd5, 6'd23);

        // Back-to-back special ops: pulses 2 cycles apart.
        do_op(ALU_DIVU, 32'd1, 32'd0, 6'd24, t1);
        do_op(ALU_REMU, 32'd3, 32'd0, 6'd25, t2);
        check("b2b_special_spacing", 32'(t2 - t1), 32'd20);
        idle_gap(32'd3, 6'd25);

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            f  = funcs[$urandom_range(0, 3)];
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            rd = 6'($urandom_range(0, 63));
            do_op(f, a, b, rd, t1);
            idle_gap(model(f, a, b), rd);
        end

        // Asynchronous reset in the middle of BUSY.
        ex_vld = 1'b1; ex_alu_func = ALU_DIVU; ex_opa = 32'd1000; ex_opb = 32'd3; ex_rd = 6'd30;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0; ex_vld = 1'b0;
        #1;
        check("arst_stall", {31'd0, div_stall}, 32'd0);
        check("arst_done", {31'd0, div_done}, 32'd0);
        check("arst_result", div_result, 32'd0);
        check("arst_rd", {26'd0, div_rd}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ex_vld = 1'b1; ex_alu_func = ALU_ADD; ex_opa = 32'd1; ex_opb = 32'd2; ex_rd = 6'd31;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("add_stall", {31'd0, div_stall}, 32'd0);
            check("add_done", {31'd0, div_done}, 32'd0);
            @(posedge clk); #1;
        end
        ex_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
